// File: rtl/lru_stack_param.sv
// True-LRU recency-stack manager: one WAYS-deep recency stack per cache set.
// Supports HIT/FILL/LOOKUP/INVAL requests with way locking and error flagging,
// plus a sequenced whole-array flush.
module lru_stack_param #(
  parameter int WAYS  = 8,
  parameter int SETS  = 128,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [1:0]             i_req_op,
  input  logic [IDX_W-1:0]       i_addr,
  input  logic [WAYS-1:0]        i_hit_way,
  input  logic [WAYS-1:0]        i_lock_mask,
  input  logic                   i_flush,
  output logic                   o_rsp_valid,
  output logic [1:0]             o_rsp_op,
  output logic                   o_rsp_err,
  output logic                   o_victim_valid,
  output logic [WAY_W-1:0]       o_victim_way,
  output logic [WAYS-1:0]        o_lru_flag,
  output logic [WAYS*WAY_W-1:0]  o_stack,
  output logic                   o_busy
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_HIT    = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [WAY_W-1:0]   mem [SETS][WAYS];

  logic               accept;
  logic               addr_ok;
  logic [IDX_W-1:0]   rd_idx;
  logic [WAY_W-1:0]   cur [WAYS];
  logic [WAY_W-1:0]   nxt [WAYS];
  logic [WAYS*WAY_W-1:0] nxt_flat;
  logic               hit_ok;
  logic [WAY_W-1:0]   hit_pos;
  logic               vic_found;
  logic [WAY_W-1:0]   vic_pos;
  logic [WAY_W-1:0]   vic_way;
  logic               err;
  logic               upd;
  logic               vvalid;
  logic               to_front;
  logic [WAY_W-1:0]   mv_pos;

  assign o_req_ready = (state == IDLE) && !i_flush;
  assign o_busy      = (state == FLUSH);
  assign accept      = i_req_valid && o_req_ready;

  // Read the addressed set and locate the hit way and the deepest unlocked way.
  always_comb begin
    addr_ok   = (32'(i_addr) < SETS);
    rd_idx    = addr_ok ? i_addr : '0;
    hit_ok    = $onehot(i_hit_way);
    hit_pos   = '0;
    vic_found = 1'b0;
    vic_pos   = '0;
    for (int p = 0; p < WAYS; p++) begin
      cur[p] = mem[rd_idx][p];
    end
    for (int p = 0; p < WAYS; p++) begin
      if (i_hit_way[cur[p]]) hit_pos = WAY_W'(p);
      // later (deeper) positions override, so the LRU-most unlocked way wins
      if (!i_lock_mask[cur[p]]) begin
        vic_found = 1'b1;
        vic_pos   = WAY_W'(p);
      end
    end
    vic_way = cur[vic_pos];
  end

  // Decode the operation into an update action, error and victim qualifier.
  always_comb begin
    err      = 1'b0;
    upd      = 1'b0;
    vvalid   = 1'b0;
    to_front = 1'b1;
    mv_pos   = '0;
    case (i_req_op)
      OP_LOOKUP: begin
        if (vic_found) vvalid = 1'b1;
        else           err    = 1'b1;
      end
      OP_HIT: begin
        if (hit_ok) begin
          upd    = 1'b1;
          mv_pos = hit_pos;
        end else begin
          err = 1'b1;
        end
      end
      OP_FILL: begin
        if (vic_found) begin
          upd    = 1'b1;
          vvalid = 1'b1;
          mv_pos = vic_pos;
        end else begin
          err = 1'b1;
        end
      end
      default: begin
        if (hit_ok) begin
          upd      = 1'b1;
          to_front = 1'b0;
          mv_pos   = hit_pos;
        end else begin
          err = 1'b1;
        end
      end
    endcase
    if (!addr_ok) begin
      err    = 1'b1;
      upd    = 1'b0;
      vvalid = 1'b0;
    end
  end

  // Build the post-update stack: move-to-front for HIT/FILL, move-to-back for INVAL.
  always_comb begin
    for (int p = 0; p < WAYS; p++) begin
      nxt[p] = cur[p];
    end
    if (upd) begin
      if (to_front) begin
        nxt[0] = cur[mv_pos];
        for (int p = 1; p < WAYS; p++) begin
          if (p <= int'(mv_pos)) nxt[p] = cur[p-1];
        end
      end else begin
        for (int p = 0; p < WAYS-1; p++) begin
          if (p >= int'(mv_pos)) nxt[p] = cur[p+1];
        end
        nxt[WAYS-1] = cur[mv_pos];
      end
    end
    nxt_flat = '0;
    for (int p = 0; p < WAYS; p++) begin
      nxt_flat[p*WAY_W +: WAY_W] = nxt[p];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: enter FLUSH on request, leave after the last set is written.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_flush) state_nxt = FLUSH;
      FLUSH:   if (cnt == IDX_W'(SETS-1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush set counter, walks 0..SETS-1 while flushing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == FLUSH) begin
      cnt <= (cnt == IDX_W'(SETS-1)) ? '0 : cnt + 1'b1;
    end
  end

  // Recency storage: default stacks on reset/flush, updated stack on accepted requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int p = 0; p < WAYS; p++) begin
          mem[s][p] <= WAY_W'(p);
        end
      end
    end else if (state == FLUSH) begin
      for (int p = 0; p < WAYS; p++) begin
        mem[cnt][p] <= WAY_W'(p);
      end
    end else if (accept && upd) begin
      for (int p = 0; p < WAYS; p++) begin
        mem[rd_idx][p] <= nxt[p];
      end
    end
  end

  // Registered response, captured on the same edge that accepts the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rsp_valid    <= 1'b0;
      o_rsp_op       <= '0;
      o_rsp_err      <= 1'b0;
      o_victim_valid <= 1'b0;
      o_victim_way   <= '0;
      o_lru_flag     <= '0;
      o_stack        <= '0;
    end else begin
      o_rsp_valid <= accept;
      if (accept) begin
        o_rsp_op       <= i_req_op;
        o_rsp_err      <= err;
        o_victim_valid <= vvalid;
        o_victim_way   <= vvalid ? vic_way : '0;
        o_lru_flag     <= WAYS'(1) << nxt[WAYS-1];
        o_stack        <= nxt_flat;
      end
    end
  end

endmodule

// File: tb/tb_lru_stack_param.sv
// Self-checking bench for lru_stack_param: directed scenarios plus randomized
// traffic against a queue-based recency model.
module tb_lru_stack_param;

  localparam int WAYS  = 8;
  localparam int SETS  = 128;
  localparam int IDX_W = 7;
  localparam int WAY_W = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [1:0]            i_req_op;
  logic [IDX_W-1:0]      i_addr;
  logic [WAYS-1:0]       i_hit_way;
  logic [WAYS-1:0]       i_lock_mask;
  logic                  i_flush;
  logic                  o_rsp_valid;
  logic [1:0]            o_rsp_op;
  logic                  o_rsp_err;
  logic                  o_victim_valid;
  logic [WAY_W-1:0]      o_victim_way;
  logic [WAYS-1:0]       o_lru_flag;
  logic [WAYS*WAY_W-1:0] o_stack;
  logic                  o_busy;

  int checks = 0;
  int errors = 0;
  int stk [SETS][$];

  lru_stack_param #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_addr(i_addr),
    .i_hit_way(i_hit_way), .i_lock_mask(i_lock_mask),
    .i_flush(i_flush),
    .o_rsp_valid(o_rsp_valid), .o_rsp_op(o_rsp_op), .o_rsp_err(o_rsp_err),
    .o_victim_valid(o_victim_valid), .o_victim_way(o_victim_way),
    .o_lru_flag(o_lru_flag), .o_stack(o_stack), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic reset_model();
    for (int s = 0; s < SETS; s++) begin
      stk[s].delete();
      for (int w = 0; w < WAYS; w++) stk[s].push_back(w);
    end
  endtask

  // Recency model: a queue per set, front = MRU, back = LRU.
  task automatic model_req(input logic [1:0] op, input int a, input logic [7:0] hw,
                           input logic [7:0] lk, output bit e, output bit vv,
                           output int vw, output logic [23:0] st);
    int q[$];
    int w;
    int idx;
    bit found;
    q = stk[a];
    e = 0; vv = 0; vw = 0; found = 0; w = 0; idx = 0;
    for (int p = WAYS-1; p >= 0; p--) begin
      if (!found && !lk[q[p]]) begin
        found = 1;
        vw = q[p];
      end
    end
    for (int b = 0; b < WAYS; b++) if (hw[b]) w = b;
    case (op)
      2'b00: begin
        if (found) vv = 1; else e = 1;
      end
      2'b10: begin
        if (!found) e = 1;
        else begin
          for (int p = 0; p < WAYS; p++) if (q[p] == vw) idx = p;
          q.delete(idx);
          q.push_front(vw);
          vv = 1;
        end
      end
      default: begin
        if ($countones(hw) != 1) e = 1;
        else begin
          for (int p = 0; p < WAYS; p++) if (q[p] == w) idx = p;
          q.delete(idx);
          if (op == 2'b01) q.push_front(w);
          else             q.push_back(w);
        end
      end
    endcase
    if (!e) stk[a] = q;
    for (int p = 0; p < WAYS; p++) st[p*3 +: 3] = 3'(stk[a][p]);
  endtask

  task automatic do_req(input logic [1:0] op, input int a, input logic [7:0] hw, input logic [7:0] lk);
    bit e, vv;
    int vw;
    logic [23:0] st;
    logic [7:0] lf;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_addr      = 7'(a);
    i_hit_way   = hw;
    i_lock_mask = lk;
    model_req(op, a, hw, lk, e, vv, vw, st);
    lf = 8'(1) << st[23:21];
    check_val("ready", 64'(o_req_ready), 64'(1));
    @(posedge clk);
    #1;
    check_val("rsp_valid", 64'(o_rsp_valid), 64'(1));
    check_val("rsp_op", 64'(o_rsp_op), 64'(op));
    check_val("rsp_err", 64'(o_rsp_err), 64'(e));
    check_val("victim_valid", 64'(o_victim_valid), 64'(vv));
    if (vv) check_val("victim_way", 64'(o_victim_way), 64'(vw));
    check_val("lru_flag", 64'(o_lru_flag), 64'(lf));
    check_val("stack", 64'(o_stack), 64'(st));
  endtask

  task automatic idle_cycle();
    i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("rsp_idle", 64'(o_rsp_valid), 64'(0));
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] hw, lk;
    rst = 1'b0;
    i_req_valid = 1'b0; i_req_op = '0; i_addr = '0;
    i_hit_way = '0; i_lock_mask = '0; i_flush = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check_val("rst_stack", 64'(o_stack), 64'(0));
    check_val("rst_busy", 64'(o_busy), 64'(0));
    check_val("rst_lru", 64'(o_lru_flag), 64'(0));
    rst = 1'b1;

    // T1: lookup on a fresh set
    do_req(2'b00, 5, 8'h00, 8'h00);
    check_val("t1_victim", 64'(o_victim_way), 64'(7));
    check_val("t1_lru", 64'(o_lru_flag), 64'h80);
    check_val("t1_stack", 64'(o_stack), 64'(pk8(0,1,2,3,4,5,6,7)));

    // T2: back-to-back hits on set 0
    do_req(2'b01, 0, 8'h20, 8'h00);
    do_req(2'b01, 0, 8'h01, 8'h00);
    do_req(2'b01, 0, 8'h04, 8'h00);
    check_val("t2_stack", 64'(o_stack), 64'(pk8(2,0,5,1,3,4,6,7)));
    check_val("t2_lru", 64'(o_lru_flag), 64'h80);

    // T3: fill with way 7 locked, then all locked
    do_req(2'b10, 0, 8'h00, 8'h80);
    check_val("t3_victim", 64'(o_victim_way), 64'(6));
    check_val("t3_stack", 64'(o_stack), 64'(pk8(6,2,0,5,1,3,4,7)));
    do_req(2'b10, 0, 8'h00, 8'hFF);
    check_val("t3_err", 64'(o_rsp_err), 64'(1));
    check_val("t3_stack2", 64'(o_stack), 64'(pk8(6,2,0,5,1,3,4,7)));

    // T4: invalidate to LRU, then malformed hit
    do_req(2'b11, 0, 8'h04, 8'h00);
    check_val("t4_stack", 64'(o_stack), 64'(pk8(6,0,5,1,3,4,7,2)));
    check_val("t4_lru", 64'(o_lru_flag), 64'h04);
    do_req(2'b01, 0, 8'h03, 8'h00);
    check_val("t4_err", 64'(o_rsp_err), 64'(1));
    check_val("t4_stack2", 64'(o_stack), 64'(pk8(6,0,5,1,3,4,7,2)));
    idle_cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        case ($urandom_range(0, 5))
          0:       hw = 8'h00;
          1:       hw = 8'($urandom);
          default: hw = 8'(1) << $urandom_range(0, 7);
        endcase
        case ($urandom_range(0, 5))
          0, 1:    lk = 8'h00;
          2:       lk = 8'hFF;
          default: lk = 8'($urandom) & 8'($urandom);
        endcase
        do_req(2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS-1)) : int'($urandom_range(0, 7)),
               hw, lk);
      end
    end
    idle_cycle();

    // T5: flush with a concurrent request held valid throughout
    i_flush = 1'b1;
    i_req_valid = 1'b1; i_req_op = 2'b00; i_addr = '0;
    i_hit_way = '0; i_lock_mask = '0;
    #1;
    check_val("t5_ready_low", 64'(o_req_ready), 64'(0));
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check_val("t5_not_accepted", 64'(o_rsp_valid), 64'(0));
    check_val("t5_busy", 64'(o_busy), 64'(1));
    n = 0; bad = 0;
    while (o_busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (o_rsp_valid) bad++;
    end
    check_val("t5_busy_cycles", 64'(n), 64'(SETS));
    check_val("t5_no_rsp_in_flush", 64'(bad), 64'(0));
    reset_model();
    do_req(2'b00, 0, 8'h00, 8'h00);
    check_val("t5_default", 64'(o_stack), 64'(pk8(0,1,2,3,4,5,6,7)));
    for (int k = 0; k < 4; k++) do_req(2'b00, int'($urandom_range(0, SETS-1)), 8'h00, 8'h00);

    // T6: reset in the middle of a flush
    do_req(2'b01, 100, 8'h10, 8'h00);
    do_req(2'b01, 127, 8'h80, 8'h00);
    i_req_valid = 1'b0;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("t6_busy_before", 64'(o_busy), 64'(1));
    rst = 1'b0;
    #1;
    check_val("t6_busy_reset", 64'(o_busy), 64'(0));
    check_val("t6_rsp_reset", 64'(o_rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    check_val("t6_rsp_hold", 64'(o_rsp_valid), 64'(0));
    rst = 1'b1;
    reset_model();
    do_req(2'b00, 100, 8'h00, 8'h00);
    check_val("t6_set100", 64'(o_stack), 64'(pk8(0,1,2,3,4,5,6,7)));
    do_req(2'b00, 127, 8'h00, 8'h00);
    check_val("t6_set127", 64'(o_stack), 64'(pk8(0,1,2,3,4,5,6,7)));
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
